// File: rtl/lcd_bus_arbiter.sv
// Two-port fixed-priority arbiter that serialises bytes onto an HD44780 4-bit write-only bus.
// Optional macro LCD_LONG_CMD_DELAY_EN adds a LONG wait after clear/home commands.
module lcd_bus_arbiter #(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 4,
    parameter int GAP_CYC    = 40,
    parameter int LONG_CYC   = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_data,
    output logic       busy,
    output logic [1:0] grant
);

    // Counter reload so a state lasts p cycles; 0 behaves as 1.
    function automatic logic [15:0] reload(input int p);
        return (p <= 1) ? 16'd0 : 16'(p - 1);
    endfunction

    if (SETUP_CYC < 0 || SETUP_CYC > 65535 || E_HIGH_CYC < 0 || E_HIGH_CYC > 65535 ||
        GAP_CYC < 0 || GAP_CYC > 65535 || LONG_CYC < 0 || LONG_CYC > 65535) begin : g_bad_param
        $error("lcd_bus_arbiter: timing parameters must lie in 0..65535");
    end

    localparam logic [15:0] SETUP_LD = reload(SETUP_CYC);
    localparam logic [15:0] E_LD     = reload(E_HIGH_CYC);
    localparam logic [15:0] GAP_LD   = reload(GAP_CYC);
`ifdef LCD_LONG_CMD_DELAY_EN
    localparam logic [15:0] LONG_LD  = reload(LONG_CYC);
`endif

    typedef enum logic [2:0] {
        IDLE, HI_SETUP, HI_E, LO_SETUP, LO_E, GAP
`ifdef LCD_LONG_CMD_DELAY_EN
        , LONG
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  data_lo;
    logic        take0, take1;
`ifdef LCD_LONG_CMD_DELAY_EN
    logic        long_q;
`endif

    assign req0_ready = (state == IDLE);
    assign req1_ready = (state == IDLE) && !req0_valid;
    assign take0      = req0_valid && req0_ready;
    assign take1      = req1_valid && req1_ready;
    assign lcd_e      = (state == HI_E) || (state == LO_E);
    assign lcd_rw     = 1'b0;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (take0 || take1) begin
                state_nxt = HI_SETUP;
                cnt_nxt   = SETUP_LD;
            end
            HI_SETUP: if (cnt == 16'd0) begin
                state_nxt = HI_E;
                cnt_nxt   = E_LD;
            end else cnt_nxt = cnt - 16'd1;
            HI_E: if (cnt == 16'd0) begin
                state_nxt = LO_SETUP;
                cnt_nxt   = SETUP_LD;
            end else cnt_nxt = cnt - 16'd1;
            LO_SETUP: if (cnt == 16'd0) begin
                state_nxt = LO_E;
                cnt_nxt   = E_LD;
            end else cnt_nxt = cnt - 16'd1;
            LO_E: if (cnt == 16'd0) begin
                state_nxt = GAP;
                cnt_nxt   = GAP_LD;
            end else cnt_nxt = cnt - 16'd1;
            GAP: if (cnt == 16'd0) begin
`ifdef LCD_LONG_CMD_DELAY_EN
                if (long_q) begin
                    state_nxt = LONG;
                    cnt_nxt   = LONG_LD;
                end else
`endif
                state_nxt = IDLE;
            end else cnt_nxt = cnt - 16'd1;
`ifdef LCD_LONG_CMD_DELAY_EN
            LONG: if (cnt == 16'd0) state_nxt = IDLE;
                  else cnt_nxt = cnt - 16'd1;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Bus pins are registered and simply hold their last value outside the nibble phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            data_lo  <= '0;
            grant    <= 2'b00;
`ifdef LCD_LONG_CMD_DELAY_EN
            long_q   <= 1'b0;
`endif
        end else begin
            if (take0 || take1) begin
                lcd_data <= take0 ? req0_data[7:4] : req1_data[7:4];
                data_lo  <= take0 ? req0_data[3:0] : req1_data[3:0];
                lcd_rs   <= take0 ? req0_rs : req1_rs;
                grant    <= take0 ? 2'b01 : 2'b10;
`ifdef LCD_LONG_CMD_DELAY_EN
                long_q   <= take0 ? (!req0_rs && (req0_data == 8'h01 || req0_data == 8'h02))
                                  : (!req1_rs && (req1_data == 8'h01 || req1_data == 8'h02));
`endif
            end
            if (state == HI_E && state_nxt == LO_SETUP)
                lcd_data <= data_lo;
            if (state == LO_E && state_nxt == GAP)
                grant <= 2'b00;
        end
    end

endmodule
